risc_net_sequencer: RTL and testbench
=====================================

Name: risc_net_sequencer

Overview:
- Fetch/decode/execute controller for the RISC-Net datapath.
- Drives the 32-bit instruction memory port (rd/wn/address/write data) and the 16-entry x 16-bit register file port (rd/wn/reg_id/write data).
- Replaces the free-running top-level glue with an explicit multi-cycle state machine.
- Instantiated between the top level and the memory/register blocks; it is the only master of both ports.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset and on restart.
- MAX_INSTR, 0, retired-instruction limit. 0 = unlimited; N>0 = enter HALT after N retirements.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse; begins execution from IDLE or HALT.
- mem_read_data  input  32  instruction memory read data; valid the cycle after mem_rd sampled.
- mem_rd  output  1  memory read strobe (1-cycle pulse).
- mem_wn  output  1  memory write strobe (1-cycle pulse).
- mem_address  output  16  memory address.
- mem_write_data  output  32  memory write data.
- reg_read_data  input  16  register read data; valid the cycle after reg_rd sampled.
- reg_rd  output  1  register read strobe.
- reg_wn  output  1  register write strobe.
- reg_id  output  4  register index.
- reg_write_data  output  16  register write data.
- pc  output  16  current program counter.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT.
- illegal  output  1  sticky: last halt was caused by an undefined opcode.
- retired  output  16  retired-instruction count; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE, pc=RESET_PC.
  - All strobes, addresses, data, reg_id, busy, halted, illegal and retired = 0.
  - Reset mid-operation aborts the instruction; no strobe is issued on the following cycle.
- Instruction format: [31:28] op, [27:24] ra, [23:20] rb, [15:0] imm/addr. Bits [19:16] are ignored.
- Opcodes:
  - 0 NOP.
  - 1 LOADI: ra=imm.
  - 2 LOAD: ra=mem[addr][15:0].
  - 3 STORE: mem[addr]={16'h0,ra}.
  - 4 ADD: ra=ra+rb.
  - 5 SUB: ra=ra-rb.
  - 6 JMP: pc=addr.
  - 7 JZ: if ra==0, pc=addr.
  - F HALT.
  - 8-E illegal: enter HALT and set illegal.
- Arithmetic is 16-bit modulo with no flags.
- States: IDLE, FETCH, FWAIT, DECODE, RDA, RDB, EXEC, MWAIT, WB, HALT.
  - IDLE: wait for start, then go to FETCH.
  - FETCH: mem_rd=1, mem_address=pc.
  - FWAIT: latch ir <= mem_read_data.
  - DECODE: reg_rd=1, reg_id=ra.
  - RDA: latch A; reg_rd=1, reg_id=rb.
  - RDB: latch B.
  - EXEC: per opcode.
    - LOAD: issue mem_rd at addr, go to MWAIT.
    - STORE: mem_wn=1, mem_write_data={16'h0,A}, retire.
    - LOADI/ADD/SUB: go to WB.
    - JMP/JZ/NOP: retire.
    - HALT/illegal: go to HALT without retiring.
  - MWAIT: latch the load data, go to WB.
  - WB: reg_wn=1, reg_id=ra, reg_write_data=result, retire.
- Retire:
  - pc = jump target if a jump is taken, else pc+1 (16'hFFFF wraps to 0).
  - retired+1.
  - If MAX_INSTR!=0 and the new retired==MAX_INSTR, go to HALT; else go to FETCH.
- Latency:
  - STORE/JMP/JZ/NOP = 6 cycles (FETCH..EXEC).
  - LOADI/ADD/SUB = 7 cycles.
  - LOAD = 8 cycles.
- Strobes:
  - Each strobe is high for exactly one cycle.
  - mem_rd and mem_wn are never high together; reg_rd and reg_wn are never high together.
  - In cycles with no strobe, address/data outputs hold their last value.
- start handling:
  - Ignored while busy.
  - In HALT: reload pc=RESET_PC, clear halted, illegal and retired, go to FETCH.
- rst and start in the same cycle: rst wins.

Optional Feature:
- Macro RISC_NET_SEQ_STEP_EN adds input port step (1 bit).
- With the macro: after each retirement the FSM enters IDLE with busy=0 instead of FETCH. A step pulse then advances it to FETCH. In that IDLE, start behaves as a step.
- Without the macro: no step port; execution is free-running as described above.

Test Plan:
- Reset, then pulse start; program: mem[0]=32'h1A00_1234 (LOADI r10,0x1234), mem[1]=32'hF000_0000 -> reg_wn cycle 7 with reg_id=10, data=0x1234; halted=1; retired=1; pc=1.
- Program: LOADI r1,5; LOADI r2,3; SUB r1,r2; STORE r1->0x0040; HALT -> mem_wn with address 0x0040, data 32'h0000_0002; retired=4.
- JZ r3 (r3=0) to 0x0010 -> pc=0x0010 after EXEC. Repeat with r3=1 -> pc increments by 1.
- Opcode 8 at pc 0 -> HALT with illegal=1 and retired=0. A start pulse then clears illegal and refetches from RESET_PC.
- Assert rst during MWAIT of a LOAD -> next cycle state IDLE, reg_wn never asserted, pc=RESET_PC.
- MAX_INSTR=3 with a loop (JMP 0x0000 at pc 0) -> halted after exactly 3 retirements, retired=3.

Source files
------------

// File: rtl/risc_net_sequencer_if.sv
// Memory and register-file port bundle driven by risc_net_sequencer.
// The sequencer is the only master of both ports.
interface risc_net_sequencer_if;
  localparam int unsigned MEM_DW = 32;
  localparam int unsigned MEM_AW = 16;
  localparam int unsigned REG_DW = 16;
  localparam int unsigned REG_IW = 4;

  logic              mem_rd;
  logic              mem_wn;
  logic [MEM_AW-1:0] mem_address;
  logic [MEM_DW-1:0] mem_write_data;
  logic [MEM_DW-1:0] mem_read_data;

  logic              reg_rd;
  logic              reg_wn;
  logic [REG_IW-1:0] reg_id;
  logic [REG_DW-1:0] reg_write_data;
  logic [REG_DW-1:0] reg_read_data;

  modport master (
    output mem_rd, mem_wn, mem_address, mem_write_data,
    output reg_rd, reg_wn, reg_id, reg_write_data,
    input  mem_read_data, reg_read_data
  );

  modport slave (
    input  mem_rd, mem_wn, mem_address, mem_write_data,
    input  reg_rd, reg_wn, reg_id, reg_write_data,
    output mem_read_data, reg_read_data
  );
endinterface

// File: rtl/risc_net_sequencer.sv
// RISC-Net fetch/decode/execute sequencer: multi-cycle FSM mastering the
// instruction memory and register file ports. All outputs are registered.
// Optional macro RISC_NET_SEQ_STEP_EN adds a step input and single-step
// operation (IDLE after every retirement, step or start advances).
module risc_net_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned MAX_INSTR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef RISC_NET_SEQ_STEP_EN
  input  logic        step,
`endif
  risc_net_sequencer_if.master bus,
  output logic [15:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam int unsigned MEM_DW = 32;
  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 16;
  localparam int unsigned IW     = 4;
  localparam int unsigned SW     = 4;

  localparam logic [SW-1:0] S_IDLE   = 4'd0;
  localparam logic [SW-1:0] S_FETCH  = 4'd1;
  localparam logic [SW-1:0] S_FWAIT  = 4'd2;
  localparam logic [SW-1:0] S_DECODE = 4'd3;
  localparam logic [SW-1:0] S_RDA    = 4'd4;
  localparam logic [SW-1:0] S_RDB    = 4'd5;
  localparam logic [SW-1:0] S_EXEC   = 4'd6;
  localparam logic [SW-1:0] S_MWAIT  = 4'd7;
  localparam logic [SW-1:0] S_WB     = 4'd8;
  localparam logic [SW-1:0] S_HALT   = 4'd9;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

`ifdef RISC_NET_SEQ_STEP_EN
  localparam logic [SW-1:0] S_RESUME = S_IDLE;
`else
  localparam logic [SW-1:0] S_RESUME = S_FETCH;
`endif

  logic [SW-1:0]     state, state_nxt;
  logic [3:0]        op, op_nxt;
  logic [IW-1:0]     ra, ra_nxt;
  logic [IW-1:0]     rb, rb_nxt;
  logic [AW-1:0]     imm, imm_nxt;
  logic [DW-1:0]     a, a_nxt;
  logic [DW-1:0]     b, b_nxt;
  logic [AW-1:0]     pc_nxt;
  logic [AW-1:0]     target;
  logic              retire;
  logic              go;
  logic              busy_nxt, halted_nxt, illegal_nxt;
  logic [DW-1:0]     retired_nxt;
  logic              mem_rd_nxt, mem_wn_nxt;
  logic [AW-1:0]     mem_address_nxt;
  logic [MEM_DW-1:0] mem_write_data_nxt;
  logic              reg_rd_nxt, reg_wn_nxt;
  logic [IW-1:0]     reg_id_nxt;
  logic [DW-1:0]     reg_write_data_nxt;

  // Instruction bits [19:16] carry no meaning and are dropped at fetch.
  logic unused_field;
  assign unused_field = ^bus.mem_read_data[19:16];

`ifdef RISC_NET_SEQ_STEP_EN
  assign go = start | step;
`else
  assign go = start;
`endif

  // State, datapath latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      op                 <= '0;
      ra                 <= '0;
      rb                 <= '0;
      imm                <= '0;
      a                  <= '0;
      b                  <= '0;
      pc                 <= RESET_PC;
      busy               <= 1'b0;
      halted             <= 1'b0;
      illegal            <= 1'b0;
      retired            <= '0;
      bus.mem_rd         <= 1'b0;
      bus.mem_wn         <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.reg_rd         <= 1'b0;
      bus.reg_wn         <= 1'b0;
      bus.reg_id         <= '0;
      bus.reg_write_data <= '0;
    end else begin
      state              <= state_nxt;
      op                 <= op_nxt;
      ra                 <= ra_nxt;
      rb                 <= rb_nxt;
      imm                <= imm_nxt;
      a                  <= a_nxt;
      b                  <= b_nxt;
      pc                 <= pc_nxt;
      busy               <= busy_nxt;
      halted             <= halted_nxt;
      illegal            <= illegal_nxt;
      retired            <= retired_nxt;
      bus.mem_rd         <= mem_rd_nxt;
      bus.mem_wn         <= mem_wn_nxt;
      bus.mem_address    <= mem_address_nxt;
      bus.mem_write_data <= mem_write_data_nxt;
      bus.reg_rd         <= reg_rd_nxt;
      bus.reg_wn         <= reg_wn_nxt;
      bus.reg_id         <= reg_id_nxt;
      bus.reg_write_data <= reg_write_data_nxt;
    end
  end

  // Next state and next outputs; strobes are set for the state being entered.
  always_comb begin
    state_nxt          = state;
    op_nxt             = op;
    ra_nxt             = ra;
    rb_nxt             = rb;
    imm_nxt            = imm;
    a_nxt              = a;
    b_nxt              = b;
    pc_nxt             = pc;
    illegal_nxt        = illegal;
    retired_nxt        = retired;
    retire             = 1'b0;
    target             = pc + 16'd1;
    mem_rd_nxt         = 1'b0;
    mem_wn_nxt         = 1'b0;
    mem_address_nxt    = bus.mem_address;
    mem_write_data_nxt = bus.mem_write_data;
    reg_rd_nxt         = 1'b0;
    reg_wn_nxt         = 1'b0;
    reg_id_nxt         = bus.reg_id;
    reg_write_data_nxt = bus.reg_write_data;

    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_nxt      = RESET_PC;
          illegal_nxt = 1'b0;
          retired_nxt = '0;
          state_nxt   = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_FWAIT;
      S_FWAIT: begin
        op_nxt     = bus.mem_read_data[31:28];
        ra_nxt     = bus.mem_read_data[27:24];
        rb_nxt     = bus.mem_read_data[23:20];
        imm_nxt    = bus.mem_read_data[15:0];
        reg_rd_nxt = 1'b1;
        reg_id_nxt = bus.mem_read_data[27:24];
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        reg_rd_nxt = 1'b1;
        reg_id_nxt = rb;
        state_nxt  = S_RDA;
      end
      S_RDA: begin
        a_nxt     = bus.reg_read_data;
        state_nxt = S_RDB;
      end
      S_RDB: begin
        b_nxt     = bus.reg_read_data;
        state_nxt = S_EXEC;
        if (op == OP_LOAD) begin
          mem_rd_nxt      = 1'b1;
          mem_address_nxt = imm;
        end else if (op == OP_STORE) begin
          mem_wn_nxt         = 1'b1;
          mem_address_nxt    = imm;
          mem_write_data_nxt = {16'h0000, a};
        end
      end
      S_EXEC: begin
        case (op)
          OP_NOP, OP_STORE: retire = 1'b1;
          OP_JMP: begin
            retire = 1'b1;
            target = imm;
          end
          OP_JZ: begin
            retire = 1'b1;
            if (a == 16'h0000) target = imm;
          end
          OP_LOAD: state_nxt = S_MWAIT;
          OP_LOADI, OP_ADD, OP_SUB: begin
            reg_wn_nxt = 1'b1;
            reg_id_nxt = ra;
            if (op == OP_LOADI)    reg_write_data_nxt = imm;
            else if (op == OP_ADD) reg_write_data_nxt = a + b;
            else                   reg_write_data_nxt = a - b;
            state_nxt = S_WB;
          end
          OP_HALT: state_nxt = S_HALT;
          default: begin
            illegal_nxt = 1'b1;
            state_nxt   = S_HALT;
          end
        endcase
      end
      S_MWAIT: begin
        reg_wn_nxt         = 1'b1;
        reg_id_nxt         = ra;
        reg_write_data_nxt = bus.mem_read_data[15:0];
        state_nxt          = S_WB;
      end
      S_WB: retire = 1'b1;
      default: state_nxt = S_IDLE;
    endcase

    if (retire) begin
      pc_nxt      = target;
      retired_nxt = retired + 16'd1;
      if ((MAX_INSTR != 0) && (retired_nxt == 16'(MAX_INSTR))) state_nxt = S_HALT;
      else state_nxt = S_RESUME;
    end

    if (state_nxt == S_FETCH) begin
      mem_rd_nxt      = 1'b1;
      mem_address_nxt = pc_nxt;
    end

    busy_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_HALT);
    halted_nxt = (state_nxt == S_HALT);
  end

endmodule

// File: tb/tb_risc_net_sequencer.sv
// Directed bench for risc_net_sequencer: table of small programs with
// hand-computed end state, plus timing, restart, reset-abort and
// MAX_INSTR sequences.
module tb_risc_net_sequencer;

  typedef struct packed {
    logic [7:0][31:0] prog;
    logic [7:0]       xaddr;
    logic [31:0]      xdata;
    logic [15:0]      ex_pc;
    logic [15:0]      ex_ret;
    logic             ex_ill;
    logic [3:0]       rid;
    logic [15:0]      rval;
    logic [7:0]       maddr;
    logic [31:0]      mval;
  } vec_t;

  localparam int NV = 9;

  logic clk = 1'b0;
  logic rst, start, start2, load_en;
  logic step = 1'b0;
  logic [15:0] pc, retired, pc2, retired2;
  logic busy, halted, illegal, busy2, halted2, illegal2;

  int n_vec = 0;
  int n_bad = 0;
  int excl_bad = 0;
  int wn_count = 0;

  logic [31:0] mem [256];
  logic [31:0] img_mem [256];
  logic [15:0] rf [16];
  vec_t vecs [NV];

  risc_net_sequencer_if bus ();
  risc_net_sequencer_if bus2 ();

  always #5 clk = ~clk;

  risc_net_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef RISC_NET_SEQ_STEP_EN
    .step(step),
`endif
    .bus(bus), .pc(pc), .busy(busy), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  risc_net_sequencer #(.MAX_INSTR(3)) u_dut_max (
    .clk(clk), .rst(rst), .start(start2),
`ifdef RISC_NET_SEQ_STEP_EN
    .step(step),
`endif
    .bus(bus2), .pc(pc2), .busy(busy2), .halted(halted2),
    .illegal(illegal2), .retired(retired2)
  );

  // Memory and register file model for the main DUT.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= img_mem[i];
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
      bus.mem_read_data <= 32'h0;
      bus.reg_read_data <= 16'h0;
    end else begin
      if (bus.mem_rd) bus.mem_read_data <= mem[bus.mem_address[7:0]];
      if (bus.mem_wn) mem[bus.mem_address[7:0]] <= bus.mem_write_data;
      if (bus.reg_rd) bus.reg_read_data <= rf[bus.reg_id];
      if (bus.reg_wn) rf[bus.reg_id] <= bus.reg_write_data;
    end
  end

  // Second DUT runs "JMP 0x0000" at every address.
  always @(posedge clk) begin
    if (bus2.mem_rd) bus2.mem_read_data <= 32'h6000_0000;
  end
  assign bus2.reg_read_data = 16'h0000;

  // Strobe exclusivity and write-back counting.
  always @(negedge clk) begin
    if ((bus.mem_rd && bus.mem_wn) || (bus.reg_rd && bus.reg_wn)) excl_bad++;
    if (bus.reg_wn) wn_count++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_image(input vec_t v);
    for (int i = 0; i < 256; i++) img_mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) img_mem[i] = v.prog[i];
    img_mem[v.xaddr] = v.xdata;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; load_en = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0; load_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk(name, 32'(halted), 32'd1);
  endtask

  initial begin
    vec_t v;
    int wn_cyc;
    logic [3:0] wn_id;
    logic [15:0] wn_data;
    logic first_rd;
    logic [15:0] first_addr;
    int base;
    logic seen;

    rst = 1'b1; start = 1'b0; start2 = 1'b0; load_en = 1'b0;

    v = '0; v.prog[0] = 32'h1A00_1234; v.prog[1] = 32'hF000_0000; v.xaddr = 8'hFF;
    v.ex_pc = 16'h0001; v.ex_ret = 16'd1; v.rid = 4'd10; v.rval = 16'h1234; v.maddr = 8'h40;
    vecs[0] = v;
    v = '0; v.prog[0] = 32'h1100_0005; v.prog[1] = 32'h1200_0003; v.prog[2] = 32'h5120_0000;
    v.prog[3] = 32'h3100_0040; v.prog[4] = 32'hF000_0000; v.xaddr = 8'hFF;
    v.ex_pc = 16'h0004; v.ex_ret = 16'd4; v.rid = 4'd1; v.rval = 16'h0002;
    v.maddr = 8'h40; v.mval = 32'h0000_0002;
    vecs[1] = v;
    v = '0; v.prog[0] = 32'h7300_0010; v.xaddr = 8'h10; v.xdata = 32'hF000_0000;
    v.ex_pc = 16'h0010; v.ex_ret = 16'd1; v.rid = 4'd3; v.rval = 16'h0000; v.maddr = 8'h40;
    vecs[2] = v;
    v = '0; v.prog[0] = 32'h1300_0001; v.prog[1] = 32'h7300_0010; v.prog[2] = 32'hF000_0000;
    v.xaddr = 8'h10; v.xdata = 32'hF000_0000;
    v.ex_pc = 16'h0002; v.ex_ret = 16'd2; v.rid = 4'd3; v.rval = 16'h0001; v.maddr = 8'h40;
    vecs[3] = v;
    v = '0; v.prog[0] = 32'h8000_0000; v.xaddr = 8'hFF;
    v.ex_pc = 16'h0000; v.ex_ret = 16'd0; v.ex_ill = 1'b1; v.maddr = 8'h40;
    vecs[4] = v;
    v = '0; v.prog[0] = 32'h1400_FFFF; v.prog[1] = 32'h1500_0002; v.prog[2] = 32'h4450_0000;
    v.prog[3] = 32'hF000_0000; v.xaddr = 8'hFF;
    v.ex_pc = 16'h0003; v.ex_ret = 16'd3; v.rid = 4'd4; v.rval = 16'h0001; v.maddr = 8'h40;
    vecs[5] = v;
    v = '0; v.prog[0] = 32'h2600_0020; v.prog[2] = 32'h6000_0005; v.prog[5] = 32'hF000_0000;
    v.xaddr = 8'h20; v.xdata = 32'hABCD_5678;
    v.ex_pc = 16'h0005; v.ex_ret = 16'd3; v.rid = 4'd6; v.rval = 16'h5678;
    v.maddr = 8'h20; v.mval = 32'hABCD_5678;
    vecs[6] = v;
    v = '0; v.prog[0] = 32'h1700_0000; v.prog[1] = 32'h1800_0001; v.prog[2] = 32'h578F_0000;
    v.prog[3] = 32'hF000_0000; v.xaddr = 8'hFF;
    v.ex_pc = 16'h0003; v.ex_ret = 16'd3; v.rid = 4'd7; v.rval = 16'hFFFF; v.maddr = 8'h40;
    vecs[7] = v;
    v = '0; v.prog[1] = 32'hE123_4567; v.xaddr = 8'hFF;
    v.ex_pc = 16'h0001; v.ex_ret = 16'd1; v.ex_ill = 1'b1; v.rid = 4'd2; v.maddr = 8'h40;
    vecs[8] = v;

    // Reset state.
    load_image(vecs[0]);
    do_reset();
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_flags", {28'h0, busy, halted, illegal, 1'b0}, 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_strobes", {28'h0, bus.mem_rd, bus.mem_wn, bus.reg_rd, bus.reg_wn}, 32'h0);
    chk("rst_addr", {bus.mem_address, 12'h0, bus.reg_id}, 32'h0);

    // MAX_INSTR=3 with a JMP 0 loop.
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (halted2) break;
    end
    chk("max_halted", 32'(halted2), 32'd1);
    chk("max_retired", 32'(retired2), 32'd3);
    chk("max_pc", 32'(pc2), 32'h0);
    repeat (20) @(negedge clk);
    chk("max_stays", {15'h0, busy2, retired2}, 32'd3);

    // LOADI write-back timing: FETCH is cycle 1, WB is cycle 7.
    pulse_start();
    wn_cyc = 0; wn_id = '0; wn_data = '0; first_rd = 1'b0; first_addr = 16'hFFFF;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin first_rd = bus.mem_rd; first_addr = bus.mem_address; end
      if (bus.reg_wn && wn_cyc == 0) begin
        wn_cyc = k; wn_id = bus.reg_id; wn_data = bus.reg_write_data;
      end
    end
    chk("t_fetch", {15'h0, first_rd, first_addr}, 32'h0001_0000);
    chk("t_wn_cycle", 32'(wn_cyc), 32'd7);
    chk("t_wn_id", 32'(wn_id), 32'd10);
    chk("t_wn_data", 32'(wn_data), 32'h1234);

    // Program table.
    for (int i = 0; i < NV; i++) begin
      load_image(vecs[i]);
      do_reset();
      pulse_start();
      wait_halt($sformatf("v%0d_halt", i));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].ex_pc));
      chk($sformatf("v%0d_retired", i), 32'(retired), 32'(vecs[i].ex_ret));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ex_ill));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_reg", i), 32'(rf[vecs[i].rid]), 32'(vecs[i].rval));
      chk($sformatf("v%0d_mem", i), mem[vecs[i].maddr], vecs[i].mval);
    end

    // Restart from an illegal halt.
    load_image(vecs[4]);
    do_reset();
    pulse_start();
    wait_halt("ill_halt1");
    chk("ill_set", 32'(illegal), 32'd1);
    pulse_start();
    @(negedge clk);
    chk("ill_restart", {busy, halted, illegal, bus.mem_rd, 12'h0, bus.mem_address}, 32'h9000_0000);
    wait_halt("ill_halt2");
    chk("ill_again", {15'h0, illegal, pc}, 32'h0001_0000);

    // Reset during MWAIT of a LOAD aborts the write-back.
    v = '0; v.prog[0] = 32'h2600_0020; v.prog[1] = 32'hF000_0000;
    v.xaddr = 8'h20; v.xdata = 32'hABCD_5678;
    load_image(v);
    do_reset();
    pulse_start();
    base = wn_count;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_address == 16'h0020) begin seen = 1'b1; break; end
    end
    chk("ab_load_rd", 32'(seen), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ab_state", {busy, halted, bus.mem_rd, bus.mem_wn, bus.reg_rd, bus.reg_wn, 10'h0, pc}, 32'h0);
    repeat (10) @(negedge clk);
    chk("ab_no_wn", 32'(wn_count - base), 32'd0);
    chk("ab_reg", 32'(rf[6]), 32'h0);
    chk("ab_idle", 32'(busy), 32'd0);

    chk("strobe_excl", 32'(excl_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
